// File: rtl/sample_gather_n.sv
// sample_gather_n: serial-to-parallel gather of NUM_INPUTS samples into one
// packed vector, with frame alignment on i_sync and a one-frame skid so the
// input keeps flowing while a finished vector waits for the consumer.
module sample_gather_n #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DWIDTH-1:0]            i_dat,
  input  logic                         i_dat_valid,
  input  logic                         i_sync,
  output logic                         o_dat_ready,
  output logic [NUM_INPUTS*DWIDTH-1:0] o_dat_vector,
  output logic                         o_dat_valid,
  input  logic                         i_dat_ready,
  output logic                         o_drop
);

  localparam int CW = $clog2(NUM_INPUTS);
  localparam logic [CW-1:0] LAST_LANE = CW'(NUM_INPUTS - 1);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [DWIDTH-1:0]            r_fill [NUM_INPUTS];
  logic [CW-1:0]                r_cnt;
  logic [0:0]                   r_state;
  logic [NUM_INPUTS*DWIDTH-1:0] r_vec;
  logic                         r_valid;
  logic                         r_drop;
  logic                         r_ready;

  logic                         w_free;
  logic                         w_accept;
  logic [NUM_INPUTS*DWIDTH-1:0] w_fill_vec;
  logic [NUM_INPUTS*DWIDTH-1:0] w_done_vec;
  logic [NUM_INPUTS-1:0]        w_lane_we;
  logic [0:0]                   w_state_next;
  logic [CW-1:0]                w_cnt_next;
  logic                         w_load;
  logic                         w_load_fill;
  logic                         w_drop_next;

  // Output slot can take a new vector if empty or being drained this cycle.
  assign w_free   = !r_valid || i_dat_ready;
  // r_ready is only high in FILL, so an accept always happens in FILL.
  assign w_accept = i_dat_valid && r_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      // A sync sample always lands in lane 0; otherwise the sample goes to lane cnt.
      assign w_lane_we[gi] = w_accept && (i_sync ? (gi == 0) : (r_cnt == CW'(gi)));
      assign w_fill_vec[gi*DWIDTH +: DWIDTH] = r_fill[gi];
      if (gi == NUM_INPUTS - 1) begin : g_last
        // Completing frame: last lane comes straight from the input.
        assign w_done_vec[gi*DWIDTH +: DWIDTH] = i_dat;
      end else begin : g_mid
        assign w_done_vec[gi*DWIDTH +: DWIDTH] = r_fill[gi];
      end

      // Per-lane fill storage.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_fill[gi] <= '0;
        end else if (w_lane_we[gi]) begin
          r_fill[gi] <= i_dat;
        end
      end
    end
  endgenerate

  // Next-state decode: lane counter, FILL/FULL, output load and drop flag.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_load_fill  = 1'b0;
    w_drop_next  = 1'b0;
    if (r_state == S_FULL) begin
      if (w_free) begin
        w_load       = 1'b1;
        w_load_fill  = 1'b1;
        w_cnt_next   = '0;
        w_state_next = S_FILL;
      end
    end else if (w_accept) begin
      if (i_sync) begin
        // Sync wins even on what would be the last lane: restart the frame.
        w_cnt_next  = CW'(1);
        w_drop_next = (r_cnt != '0);
      end else if (r_cnt == LAST_LANE) begin
        if (w_free) begin
          w_load     = 1'b1;
          w_cnt_next = '0;
        end else begin
          w_state_next = S_FULL;
        end
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  // Control and output registers; ready is registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_drop  <= w_drop_next;
      r_ready <= (w_state_next == S_FILL);
      if (w_load) begin
        r_vec   <= w_load_fill ? w_fill_vec : w_done_vec;
        r_valid <= 1'b1;
      end else if (i_dat_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dat_ready  = r_ready;
  assign o_dat_vector = r_vec;
  assign o_dat_valid  = r_valid;
  assign o_drop       = r_drop;

endmodule

// File: tb/tb_sample_gather_n.sv
// Testbench for sample_gather_n: scoreboard-checked N=16/DW=8 instance plus a
// small N=4/DW=12 instance.
module tb_sample_gather_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=16, DW=8 instance
  logic         rst16;
  logic [7:0]   d_dat;
  logic         d_valid, d_sync, d_rdy;
  logic         o_ready, o_valid, o_drop;
  logic [127:0] o_vec;

  // N=4, DW=12 instance
  logic         rst4;
  logic [11:0]  e_dat;
  logic         e_valid, e_sync, e_rdy;
  logic         e_ready, e_ovalid, e_drop;
  logic [47:0]  e_vec;

  sample_gather_n #(.NUM_INPUTS(16), .DWIDTH(8)) dut16 (
    .clk(clk), .rst(rst16), .i_dat(d_dat), .i_dat_valid(d_valid), .i_sync(d_sync),
    .o_dat_ready(o_ready), .o_dat_vector(o_vec), .o_dat_valid(o_valid),
    .i_dat_ready(d_rdy), .o_drop(o_drop)
  );

  sample_gather_n #(.NUM_INPUTS(4), .DWIDTH(12)) dut4 (
    .clk(clk), .rst(rst4), .i_dat(e_dat), .i_dat_valid(e_valid), .i_sync(e_sync),
    .o_dat_ready(e_ready), .o_dat_vector(e_vec), .o_dat_valid(e_ovalid),
    .i_dat_ready(e_rdy), .o_drop(e_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model and scoreboard
  logic [7:0]   m_buf [16];
  int           m_idx = 0;
  logic [127:0] sb [$];
  logic [127:0] last_vec;
  int           n_drops = 0;

  task automatic model_reset();
    m_idx = 0;
    sb.delete();
  endtask

  // One cycle: drive at negedge, resolve handshakes, advance to next negedge.
  task automatic step(input logic [7:0] dat, input logic v, input logic s,
                      input logic r, output logic acc);
    logic [127:0] e;
    logic         pend_drop;
    d_dat = dat; d_valid = v; d_sync = s; d_rdy = r;
    if (o_valid && r) begin
      if (sb.size() == 0) begin
        check_eq("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("vector", o_vec, e);
        $display("vec out %h exp %h", o_vec, e);
      end
      last_vec = o_vec;
    end
    acc = v && o_ready;
    pend_drop = 1'b0;
    if (acc) begin
      if (s) begin
        pend_drop = (m_idx != 0);
        m_buf[0] = dat;
        m_idx = 1;
      end else begin
        m_buf[m_idx] = dat;
        m_idx++;
        if (m_idx == 16) begin
          for (int k = 0; k < 16; k++) e[k*8 +: 8] = m_buf[k];
          sb.push_back(e);
          m_idx = 0;
        end
      end
    end
    @(negedge clk);
    check_eq("drop", o_drop, pend_drop);
    if (o_drop) n_drops++;
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 20 && (sb.size() != 0 || o_valid); c++) step(8'h00, 0, 0, 1, acc);
    check_eq("drain_sb_left", sb.size(), 0);
    check_eq("drain_valid", o_valid, 0);
  endtask

  initial begin
    logic        acc;
    logic        ready_dropped;
    int          n_acc;
    logic [11:0] s4 [4];

    rst16 = 1'b0; rst4 = 1'b0;
    d_dat = '0; d_valid = 0; d_sync = 0; d_rdy = 1;
    e_dat = '0; e_valid = 0; e_sync = 0; e_rdy = 1;

    // Reset held 3 cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_vec", o_vec, 0);
      check_eq("rst_drop", o_drop, 0);
      check_eq("rst_ready", o_ready, 0);
    end
    rst16 = 1'b1; rst4 = 1'b1;
    check_eq("ready_at_release", o_ready, 0);
    @(negedge clk);
    check_eq("ready_after_release", o_ready, 1);
    check_eq("ready4_after_release", e_ready, 1);

    // Basic frame
    ready_dropped = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(8'(k), 1, 0, 1, acc);
      if (!o_ready) ready_dropped = 1'b1;
    end
    check_eq("basic_valid", o_valid, 1);
    step(8'h00, 0, 0, 1, acc);
    check_eq("basic_vec_literal", last_vec, 128'h0F0E0D0C0B0A09080706050403020100);
    check_eq("basic_valid_one_cycle", o_valid, 0);
    check_eq("basic_ready_never_dropped", ready_dropped, 0);

    // Backpressure: stream 32 samples with consumer stalled
    n_acc = 0;
    for (int c = 0; c < 200 && n_acc < 32; c++) begin
      step(8'(n_acc), 1, 0, 0, acc);
      if (acc) n_acc++;
    end
    check_eq("bp_accepted", n_acc, 32);
    check_eq("bp_ready_low", o_ready, 0);
    check_eq("bp_valid", o_valid, 1);
    step(8'h00, 0, 0, 1, acc);
    check_eq("bp_first_vec", last_vec, 128'h0F0E0D0C0B0A09080706050403020100);
    check_eq("bp_ready_back", o_ready, 1);
    check_eq("bp_second_valid", o_valid, 1);
    step(8'h00, 0, 0, 1, acc);
    check_eq("bp_second_vec", last_vec, 128'h1F1E1D1C1B1A19181716151413121110);
    drain();

    // Sync realignment
    n_drops = 0;
    for (int k = 0; k < 5; k++) step(8'(8'hA0 + k), 1, 0, 1, acc);
    step(8'h00, 1, 1, 1, acc);
    for (int k = 1; k < 16; k++) step(8'(k), 1, 0, 1, acc);
    drain();
    check_eq("sync_drop_count", n_drops, 1);
    check_eq("sync_vec", last_vec, 128'h0F0E0D0C0B0A09080706050403020100);

    // Reset while FULL with a vector held
    n_acc = 0;
    for (int c = 0; c < 200 && n_acc < 32; c++) begin
      step(8'(8'h40 + n_acc), 1, 0, 0, acc);
      if (acc) n_acc++;
    end
    check_eq("full_valid", o_valid, 1);
    check_eq("full_ready", o_ready, 0);
    d_valid = 0;
    #2 rst16 = 1'b0;
    #1;
    check_eq("async_rst_valid", o_valid, 0);
    check_eq("async_rst_vec", o_vec, 0);
    check_eq("async_rst_ready", o_ready, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    check_eq("rst2_ready", o_ready, 1);
    for (int k = 0; k < 16; k++) step(8'(8'hC0 + k), 1, 0, 1, acc);
    drain();
    check_eq("rst2_vec", last_vec, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);

    // Random traffic with random stalls and occasional sync
    for (int c = 0; c < 600; c++) begin
      step(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 1) == 1), acc);
    end
    drain();

    // N=4, DW=12 instance
    s4[0] = 12'h123; s4[1] = 12'h456; s4[2] = 12'h789; s4[3] = 12'hABC;
    for (int k = 0; k < 4; k++) begin
      e_dat = s4[k]; e_valid = 1'b1;
      @(negedge clk);
    end
    e_valid = 1'b0;
    check_eq("n4_valid", e_ovalid, 1);
    check_eq("n4_vec", e_vec, 48'hABC789456123);
    $display("n4 vec out %h", e_vec);
    @(negedge clk);
    check_eq("n4_valid_cleared", e_ovalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_gather_n.md
# sample_gather_n

Serial-to-parallel gather stage that accepts one DWIDTH-bit sample per cycle and emits a packed vector of NUM_INPUTS samples. It sits directly upstream of the N-at-a-time averaging/summing stages and drives their `i_dat_vector`/`i_dat_valid` inputs. It adds frame alignment (`i_sync`) and a ready/valid handshake on both sides. With a one-frame skid, the upstream stream keeps flowing while a finished vector waits for the consumer.

## Interface
- `NUM_INPUTS`, 16: samples per output vector; power of 2, ≥ 2.
- `DWIDTH`, 8: bits per sample.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `i_dat`  in  DWIDTH  input sample.
- `i_dat_valid`  in  1  sample present.
- `i_sync`  in  1  qualified by an accepted sample; marks that sample as lane 0 of a new frame.
- `o_dat_ready`  out  1  stage can accept a sample; a sample is accepted when `i_dat_valid & o_dat_ready`.
- `o_dat_vector`  out  NUM_INPUTS*DWIDTH  packed frame; lane k at bits [k*DWIDTH +: DWIDTH], lane 0 is the first sample of the frame.
- `o_dat_valid`  out  1  vector present; held until consumed.
- `i_dat_ready`  in  1  downstream accepts; the vector transfers when `o_dat_valid & i_dat_ready`. Tie high for consumers without backpressure.
- `o_drop`  out  1  one-cycle pulse: a partial frame was discarded by `i_sync`.

## Operation
- **Storage**
  - Fill register: NUM_INPUTS lanes.
  - Lane counter `cnt`: $clog2(NUM_INPUTS) bits.
  - Output register: `o_dat_vector` plus `o_dat_valid`.
  - State: FILL or FULL.
- **Output slot free:** `free = !o_dat_valid | i_dat_ready`.
- **FILL, accepted sample, not last lane:**
  - The sample is written to lane `cnt`.
  - `cnt` increments.
- **FILL, accepted sample with `cnt == NUM_INPUTS-1` and `free`:**
  - The output register loads the fill lanes 0..N-2 plus the current sample in lane N-1.
  - `o_dat_valid` goes to 1 and `cnt` goes to 0.
  - State stays FILL.
- **FILL, last lane accepted and not `free`:**
  - The sample is written to lane N-1.
  - State goes to FULL and `o_dat_ready` goes to 0.
- **FULL:**
  - No samples are accepted.
  - When `free`, the output register loads the fill register, `o_dat_valid` goes to 1, `cnt` goes to 0, and state goes to FILL.
- **Output consumed with no new load in the same cycle:** `o_dat_valid` goes to 0. `o_dat_vector` holds its last value.
- **`i_sync` on an accepted sample:**
  - The sample is written to lane 0 and `cnt` becomes 1.
  - If `cnt != 0` beforehand, the partial frame is discarded and `o_drop` pulses the next cycle.
  - `i_sync` with `cnt == 0` is a normal lane-0 sample with no drop.
  - When `NUM_INPUTS` would complete on that sample, `i_sync` still takes priority: it restarts the frame.
- **`i_sync` ignored:** when the sample is not accepted (no valid, or FULL).
- **Lane ownership:** lanes left stale after a drop are never emitted, because every lane is rewritten before the next emission.
- **Ordering:** vectors are emitted strictly in completion order. No vector is lost or duplicated under any backpressure pattern.

## Timing
- **Reset values (while `rst`=0):**
  - `o_dat_vector` = 0, `o_dat_valid` = 0, `o_drop` = 0.
  - `o_dat_ready` = 0, `cnt` = 0, state FILL.
- **Ready after reset:** `o_dat_ready` is registered; it rises on the first clock edge after `rst` deasserts.
- **Ready update:** `o_dat_ready` equals (next state == FILL).
  - It falls in the cycle after the blocking last-lane accept.
  - It rises in the cycle after the FULL→FILL transfer.
- **Latency:** last-lane sample accepted at edge t → `o_dat_valid` = 1 after edge t.
- **Throughput:** with `i_dat_ready` = 1, one sample per cycle is sustained indefinitely and `o_dat_ready` stays 1.
- **Skid:** with the consumer stalled, the stage absorbs exactly one further complete frame, then deasserts `o_dat_ready`.
- **Reset mid-frame or mid-FULL:** all partial and held data is abandoned. Outputs return to reset values immediately (asynchronous).

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release → all outputs 0 during reset; `o_dat_ready` = 1 one cycle after release.
- **Basic frame (N=16, DW=8, `i_dat_ready`=1):** send samples 0x00..0x0F back-to-back → one cycle after 0x0F, `o_dat_vector` = 0x0F0E0D0C0B0A09080706050403020100 with `o_dat_valid` high for 1 cycle. `o_dat_ready` never drops.
- **Backpressure:** `i_dat_ready`=0; stream 0x00..0x1F continuously → `o_dat_ready` drops after 0x1F is accepted. Raise `i_dat_ready` → vector 0x0F..00, then vector 0x1F..10, on consecutive cycles. `o_dat_ready` returns to 1 after the second load.
- **Sync realignment:** send 5 samples (0xA0..0xA4), then 0x00 with `i_sync`=1, then 0x01..0x0F → `o_drop` pulses once. The emitted vector is 0x0F..00, with no 0xAx lanes.
- **Reset mid-operation:** assert `rst` while FULL with `o_dat_valid`=1 → outputs clear immediately. After release, a fresh 16-sample frame emits correctly with no stale lanes.
- **Parameter sweep (N=4, DW=12):** send 0x123, 0x456, 0x789, 0xABC → `o_dat_vector` = 0xABC789456123. Repeat the N=16 random-stall run and check against a reference queue for order and loss.
